// File: rtl/circuito_exp3_pkg.sv
// Experiment 3 shared definitions: FSM state codes and ROM contents.
// Imported by the top and the 7-segment decoder.
package circuito_exp3_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        REGISTRA   = 4'h4,
        COMPARACAO = 4'h5,
        PROXIMO    = 4'h6,
        FINAL      = 4'hF
    } estado_t;

    // Word 15 in the top nibble, word 0 in the bottom nibble.
    localparam logic [63:0] ROM_TAB = {
        4'h4, 4'h1, 4'h8, 4'h8,
        4'h4, 4'h4, 4'h2, 4'h2,
        4'h1, 4'h1, 4'h2, 4'h4,
        4'h8, 4'h4, 4'h2, 4'h1
    };

    function automatic logic [3:0] rom_read(input logic [3:0] addr);
        return ROM_TAB[{addr, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/circuito_exp3_hexa7seg.sv
// Hex digit to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
// Purely combinational; instantiated once per board display.
module hexa7seg
    import circuito_exp3_pkg::*;
(
    input  logic [3:0] hexa,
    output logic [6:0] seg
);

    // Segment lookup for digits 0..F
    always_comb begin
        seg = 7'b1111111;
        unique case (hexa)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/circuito_exp3.sv
// Experiment 3 top: control unit sweeping a 16-word ROM and comparing
// each word against registered switches, with 7-segment debug outputs.
module circuito_exp3
    import circuito_exp3_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);

    estado_t    estado_q, estado_d;
    logic [3:0] contagem_q, contagem_d;
    logic [3:0] chaves_q, chaves_d;
    logic       pronto_q;

    logic       zera_c, conta_c;
    logic       zera_r, registra_r;
    logic       fim_c;
    logic [3:0] memoria;

    assign fim_c   = (contagem_q == 4'hF);
    assign memoria = rom_read(contagem_q);

    // Moore control signals decoded from the current state
    always_comb begin
        zera_c     = 1'b0;
        conta_c    = 1'b0;
        zera_r     = 1'b0;
        registra_r = 1'b0;
        unique case (estado_q)
            PREPARACAO: begin
                zera_c = 1'b1;
                zera_r = 1'b1;
            end
            REGISTRA: registra_r = 1'b1;
            PROXIMO:  conta_c    = 1'b1;
            default:  ;
        endcase
    end

    // Next-state logic; unused codes fall back to INICIAL
    always_comb begin
        estado_d = INICIAL;
        unique case (estado_q)
            INICIAL:    estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: estado_d = REGISTRA;
            REGISTRA:   estado_d = COMPARACAO;
            COMPARACAO: estado_d = fim_c ? FINAL : PROXIMO;
            PROXIMO:    estado_d = REGISTRA;
            FINAL:      estado_d = iniciar ? PREPARACAO : FINAL;
            default:    estado_d = INICIAL;
        endcase
    end

    // State register with registered pronto tracking the FINAL state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            pronto_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            pronto_q <= (estado_d == FINAL);
        end
    end

    // Address counter: clear wins over increment
    always_comb begin
        contagem_d = contagem_q;
        if (zera_c) begin
            contagem_d = 4'h0;
        end else if (conta_c) begin
            contagem_d = contagem_q + 4'h1;
        end
    end

    // Counter flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem_q <= 4'h0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    // Switch register: clear wins over load
    always_comb begin
        chaves_d = chaves_q;
        if (zera_r) begin
            chaves_d = 4'h0;
        end else if (registra_r) begin
            chaves_d = chaves;
        end
    end

    // Switch register flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chaves_q <= 4'h0;
        end else begin
            chaves_q <= chaves_d;
        end
    end

    assign pronto     = pronto_q;
    assign db_igual   = (chaves_q == memoria);
    assign db_iniciar = iniciar;

    hexa7seg u_hex_contagem (
        .hexa (contagem_q),
        .seg  (db_contagem)
    );

    hexa7seg u_hex_memoria (
        .hexa (memoria),
        .seg  (db_memoria)
    );

    hexa7seg u_hex_chaves (
        .hexa (chaves_q),
        .seg  (db_chaves)
    );

    hexa7seg u_hex_estado (
        .hexa (estado_q),
        .seg  (db_estado)
    );

endmodule

// File: tb/tb_circuito_exp3.sv
// Self-checking bench for circuito_exp3: timeline model of the ROM sweep
// with random switches, random ignored starts, restarts and aborts.
module tb_circuito_exp3;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] chaves;
    logic       pronto;
    logic       db_igual;
    logic       db_iniciar;
    logic [6:0] db_contagem;
    logic [6:0] db_memoria;
    logic [6:0] db_chaves;
    logic [6:0] db_estado;

    int n_vec;
    int n_err;

    // model state between scenarios
    int m_cnt;
    int m_reg;
    int m_st;

    int rom_ref [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

    circuito_exp3 dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .chaves      (chaves),
        .pronto      (pronto),
        .db_igual    (db_igual),
        .db_iniciar  (db_iniciar),
        .db_contagem (db_contagem),
        .db_memoria  (db_memoria),
        .db_chaves   (db_chaves),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] hex7(input int v);
        logic [6:0] s;
        case (v & 15)
            0:  s = 7'b1000000;
            1:  s = 7'b1111001;
            2:  s = 7'b0100100;
            3:  s = 7'b0110000;
            4:  s = 7'b0011001;
            5:  s = 7'b0010010;
            6:  s = 7'b0000010;
            7:  s = 7'b1111000;
            8:  s = 7'b0000000;
            9:  s = 7'b0010000;
            10: s = 7'b0001000;
            11: s = 7'b0000011;
            12: s = 7'b1000110;
            13: s = 7'b0100001;
            14: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        iniciar = 1'b0;
        chaves = 4'h0;
        @(negedge clock);
        n_vec++;
        if (db_estado !== 7'b1000000 || pronto !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got est=%b pronto=%b expected est=1000000 pronto=0",
                     db_estado, pronto);
        end
        n_vec++;
        if (db_contagem !== 7'b1000000 || db_chaves !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_datapath: got cnt=%b chv=%b expected 1000000 both",
                     db_contagem, db_chaves);
        end
        reset = 1'b1;
        m_cnt = 0;
        m_reg = 0;
        m_st = 0;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 5; i++) begin
            chaves = 4'($urandom);
            @(negedge clock);
            n_vec++;
            if (db_estado !== hex7(0) || db_contagem !== hex7(0) || pronto !== 1'b0) begin
                n_err++;
                $display("FAIL idle c%0d: got est=%b cnt=%b pronto=%b expected est=%b cnt=%b pronto=0",
                         i, db_estado, db_contagem, pronto, hex7(0), hex7(0));
            end
        end
    endtask

    // One sweep from INICIAL/FINAL. mode 0: chaves = ROM word,
    // 1: random chaves and noise, 2: chaves fixed at 4'b0100.
    // stop_k > 0 aborts with reset during that cycle.
    task automatic sweep(input int mode, input int stop_k);
        int st;
        int a;
        int ph;
        int cnt;
        if (mode == 2) chaves = 4'b0100;
        iniciar = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            @(negedge clock);
            if (k == 1) begin
                st = 1;
                cnt = m_cnt;
            end else begin
                a = (k - 2) / 3;
                ph = (k - 2) % 3;
                cnt = a;
                st = (a == 15 && ph == 2) ? 15 : 4 + ph;
                if (k == 2) m_reg = 0;
            end
            n_vec++;
            if (db_estado !== hex7(st)) begin
                n_err++;
                $display("FAIL estado k=%0d: got %b expected %b", k, db_estado, hex7(st));
            end
            n_vec++;
            if (db_contagem !== hex7(cnt) || db_memoria !== hex7(rom_ref[cnt])) begin
                n_err++;
                $display("FAIL contagem k=%0d: got cnt=%b mem=%b expected cnt=%b mem=%b",
                         k, db_contagem, db_memoria, hex7(cnt), hex7(rom_ref[cnt]));
            end
            n_vec++;
            if (db_chaves !== hex7(m_reg)) begin
                n_err++;
                $display("FAIL chaves_reg k=%0d: got %b expected %b", k, db_chaves, hex7(m_reg));
            end
            n_vec++;
            if (db_igual !== (m_reg == rom_ref[cnt])) begin
                n_err++;
                $display("FAIL igual k=%0d: got %b expected %b", k, db_igual,
                         (m_reg == rom_ref[cnt]));
            end
            n_vec++;
            if (pronto !== (st == 15) || db_iniciar !== iniciar) begin
                n_err++;
                $display("FAIL pronto k=%0d: got pronto=%b dbini=%b expected pronto=%b dbini=%b",
                         k, pronto, db_iniciar, (st == 15), iniciar);
            end
            if (k == stop_k) begin
                #2 reset = 1'b0;
                #1;
                n_vec++;
                if (db_estado !== hex7(0) || db_contagem !== hex7(0) ||
                    db_chaves !== hex7(0) || pronto !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort k=%0d: got est=%b cnt=%b chv=%b pronto=%b expected %b %b %b 0",
                             k, db_estado, db_contagem, db_chaves, pronto,
                             hex7(0), hex7(0), hex7(0));
                end
                #1 reset = 1'b1;
                iniciar = 1'b0;
                m_cnt = 0;
                m_reg = 0;
                m_st = 0;
                return;
            end
            if (k >= 2 && k <= 46 && mode == 1)
                iniciar = 1'($urandom);
            else
                iniciar = 1'b0;
            if (st == 4) begin
                if (mode == 0) chaves = 4'(rom_ref[cnt]);
                else if (mode == 1) chaves = 4'($urandom);
                else chaves = 4'b0100;
                m_reg = int'(chaves);
            end else if (mode == 1) begin
                chaves = 4'($urandom);
            end
        end
        m_cnt = 15;
        m_st = 15;
    endtask

    task automatic test_start_compare;
        sweep(2, 0);
    endtask

    task automatic test_full_sweep;
        sweep(0, 0);
    endtask

    task automatic test_final_hold;
        for (int i = 0; i < 4; i++) begin
            iniciar = 1'b0;
            chaves = 4'($urandom);
            @(negedge clock);
            n_vec++;
            if (pronto !== 1'b1 || db_estado !== 7'b0001110 || db_contagem !== hex7(15)) begin
                n_err++;
                $display("FAIL final_hold c%0d: got pronto=%b est=%b cnt=%b expected 1 0001110 %b",
                         i, pronto, db_estado, db_contagem, hex7(15));
            end
        end
    endtask

    task automatic test_restart;
        sweep(1, 0);
        sweep(0, 0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) sweep(1, 0);
    endtask

    task automatic test_abort;
        for (int r = 0; r < 3; r++) begin
            sweep(1, int'($urandom_range(2, 48)));
            @(negedge clock);
            n_vec++;
            if (db_estado !== hex7(0) || db_contagem !== hex7(0) || pronto !== 1'b0) begin
                n_err++;
                $display("FAIL post_abort r%0d: got est=%b cnt=%b pronto=%b expected %b %b 0",
                         r, db_estado, db_contagem, pronto, hex7(0), hex7(0));
            end
        end
        sweep(0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        iniciar = 1'b0;
        chaves = 4'h0;
        test_reset();
        test_idle();
        test_start_compare();
        test_final_hold();
        test_full_sweep();
        test_final_hold();
        test_restart();
        test_random();
        test_abort();
        test_final_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
